// File: rtl/mix_columns_serial.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_serial
// Brief    : AES MixColumns stage, column-serial, valid/ready on both sides.
//            Define MIX_COLUMNS_INV_EN to add i_inverse (InvMixColumns).
// Revision : 1.0  initial release
// ============================================================================
module mix_columns_serial #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic [0:127] i_data,
  input  logic         i_valid,
  input  logic         i_bypass,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         i_inverse,
`endif
  output logic         o_ready,
  output logic [0:127] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_serial: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Start column of the final group; the 2-bit cast makes the step wrap to 0 for 4.
  localparam logic [1:0] C_LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] C_COL_STEP = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [1:0]   r_col_cnt;
  logic [0:127] r_work;
  logic [0:127] w_work_mixed;
  logic         w_accept;
`ifdef MIX_COLUMNS_INV_EN
  logic         r_inverse;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Column word: row 0 in the top byte.
  function automatic logic [31:0] get_col(input logic [0:127] w, input logic [1:0] c);
    logic [31:0] col;
    col = '0;
    for (int r = 0; r < 4; r++) col[8*(3-r) +: 8] = w[32*r + 8*int'(c) +: 8];
    return col;
  endfunction

  function automatic logic [0:127] put_col(input logic [0:127] w, input logic [1:0] c,
                                           input logic [31:0] col);
    logic [0:127] res;
    res = w;
    for (int r = 0; r < 4; r++) res[32*r + 8*int'(c) +: 8] = col[8*(3-r) +: 8];
    return res;
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] s);
    logic [7:0] s0, s1, s2, s3, d0, d1, d2, d3;
    {s0, s1, s2, s3} = s;
    d0 = xt(s0); d1 = xt(s1); d2 = xt(s2); d3 = xt(s3);
    return {d0 ^ d1 ^ s1 ^ s2 ^ s3,
            s0 ^ d1 ^ d2 ^ s2 ^ s3,
            s0 ^ s1 ^ d2 ^ d3 ^ s3,
            d0 ^ s0 ^ s1 ^ s2 ^ d3};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  // sel: 0 -> 0e, 1 -> 0b, 2 -> 0d, 3 -> 09 (coefficient offset from the diagonal)
  function automatic logic [7:0] inv_mul(input logic [7:0] b, input logic [1:0] sel);
    logic [7:0] x2, x4, x8, p;
    x2 = xt(b); x4 = xt(x2); x8 = xt(x4);
    case (sel)
      2'd0:    p = x8 ^ x4 ^ x2;
      2'd1:    p = x8 ^ x2 ^ b;
      2'd2:    p = x8 ^ x4 ^ b;
      default: p = x8 ^ b;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] s);
    logic [31:0] m;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++)
        m[8*(3-r) +: 8] = m[8*(3-r) +: 8] ^ inv_mul(s[8*(3-i) +: 8], 2'(i - r));
    return m;
  endfunction
`endif

  always_comb begin
    w_work_mixed = r_work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
`ifdef MIX_COLUMNS_INV_EN
      w_work_mixed = put_col(w_work_mixed, r_col_cnt + 2'(g),
                             r_inverse ? mix_inv(get_col(r_work, r_col_cnt + 2'(g)))
                                       : mix_fwd(get_col(r_work, r_col_cnt + 2'(g))));
`else
      w_work_mixed = put_col(w_work_mixed, r_col_cnt + 2'(g),
                             mix_fwd(get_col(r_work, r_col_cnt + 2'(g))));
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_accept     = 1'b1;
          w_state_next = i_bypass ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: if (r_col_cnt == C_LAST_COL) w_state_next = S_DONE;
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_col_cnt <= 2'd0;
      r_work    <= '0;
`ifdef MIX_COLUMNS_INV_EN
      r_inverse <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_work    <= i_data;
        r_col_cnt <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
        r_inverse <= i_inverse;
`endif
      end else if (r_state == S_BUSY) begin
        r_work    <= w_work_mixed;
        r_col_cnt <= r_col_cnt + C_COL_STEP;
      end
    end
  end

  // Work register only changes on accept or in BUSY, so it is stable throughout DONE.
  assign o_data = r_work;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_serial
// Brief    : Scoreboard bench for mix_columns_serial at COLS_PER_CYCLE 1, 2, 4.
// Revision : 1.0  initial release
// ============================================================================
module tb_mix_columns_serial;

  typedef struct {
    logic [0:127] data;
    int           lat;
    int           acc;
  } exp_t;

  // FIPS-197 columns db135345 f20a225c 01010101 2d26314c, row-major.
  localparam logic [0:127] V_IN   = 128'hdbf2012d_130a0126_53220131_455c014c;
  localparam logic [0:127] V_OUT  = 128'h8e9f014d_4ddc017e_a15801bd_bc9d01f8;
  // Columns d4d4d4d5 c6c6c6c6 2d26314c db135345.
  localparam logic [0:127] V2_IN  = 128'hd4c62ddb_d4c62613_d4c63153_d5c64c45;
  localparam logic [0:127] V2_OUT = 128'hd5c64d8e_d5c67e4d_d7c6bda1_d6c6f8bc;
  localparam logic [0:127] V_BYP  = 128'h01234567_89abcdef_fedcba98_76543210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int cpc, input logic [0:127] got,
                     input logic [0:127] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cpc=%0d: got %h required %h", name, cpc, got, exp);
    end
  endtask

`ifdef MIX_COLUMNS_INV_EN
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [0:127] model_mix(input logic [0:127] x);
    logic [0:127] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[32*r + 8*c +: 8] = gmul(8'h02, x[32*r + 8*c +: 8])
                           ^ gmul(8'h03, x[32*((r+1)%4) + 8*c +: 8])
                           ^ x[32*((r+2)%4) + 8*c +: 8]
                           ^ x[32*((r+3)%4) + 8*c +: 8];
    return y;
  endfunction
`endif

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CPC = 1 << k;
    localparam int L   = 4 / CPC;

    logic         rst_n, vld, byp, rdy_in, o_rdy, o_vld, done;
    logic         inv;
    logic [0:127] din, dout;
    exp_t         q[$];
    exp_t         e;
    bit           seen;

    mix_columns_serial #(.COLS_PER_CYCLE(CPC)) u_dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .i_data    (din),
      .i_valid   (vld),
      .i_bypass  (byp),
`ifdef MIX_COLUMNS_INV_EN
      .i_inverse (inv),
`endif
      .o_ready   (o_rdy),
      .o_data    (dout),
      .o_valid   (o_vld),
      .i_ready   (rdy_in)
    );

    // Monitor: checks each newly presented result against the scoreboard head.
    always @(negedge clk) begin
      if (!rst_n) begin
        seen = 1'b0;
      end else if (o_vld && !seen) begin
        seen = 1'b1;
        chk("expected_pending", CPC, 128'(q.size() != 0), 128'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("o_data", CPC, dout, e.data);
          chk("latency", CPC, 128'(cyc - e.acc), 128'(e.lat));
        end
      end else if (!o_vld) begin
        seen = 1'b0;
      end
    end

    task automatic send(input logic [0:127] d, input logic b, input logic iv,
                        input logic [0:127] exp, output int acc);
      int t;
      din = d; byp = b; vld = 1'b1;
      inv = iv;
      t = 0;
      while (!o_rdy && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!o_rdy) chk("accept_timeout", CPC, 128'(o_rdy), 128'd1);
      @(posedge clk);
      acc = cyc;
      q.push_back('{exp, (b ? 1 : L + 1), acc});
      @(negedge clk);
      vld = 1'b0;
      din = {$urandom, $urandom, $urandom, $urandom};
      byp = 1'($urandom);
      inv = 1'($urandom);
    endtask

    task automatic wait_out();
      int t;
      t = 0;
      while (!o_vld && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!o_vld) chk("o_valid_timeout", CPC, 128'(o_vld), 128'd1);
    endtask

    initial begin
      int a0, a1, rel, t;
      logic [0:127] x, y;
      done = 1'b0; seen = 1'b0;
      rst_n = 1'b0; vld = 1'b1; din = V_IN; byp = 1'b0; inv = 1'b0; rdy_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_o_valid", CPC, 128'(o_vld), 128'd0);
      chk("rst_o_data",  CPC, dout, '0);
      chk("rst_o_ready", CPC, 128'(o_rdy), 128'd1);

      rst_n = 1'b1;
      rel = cyc;
      send(V_IN, 1'b0, 1'b0, V_OUT, a0);
      chk("first_accept_edge", CPC, 128'(a0), 128'(rel));

      send(V2_IN, 1'b0, 1'b0, V2_OUT, a0);
      send('0, 1'b0, 1'b0, '0, a0);
      send(V_BYP, 1'b1, 1'b0, V_BYP, a0);

      send(V_IN, 1'b0, 1'b0, V_OUT, a0);
      send(V2_IN, 1'b0, 1'b0, V2_OUT, a1);
      chk("throughput", CPC, 128'(a1 - a0), 128'(L + 2));

      wait_out();
      @(negedge clk);
      rdy_in = 1'b0;
      send(V2_IN, 1'b0, 1'b0, V2_OUT, a0);
      wait_out();
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("bp_o_data",  CPC, dout, V2_OUT);
        chk("bp_o_valid", CPC, 128'(o_vld), 128'd1);
        chk("bp_o_ready", CPC, 128'(o_rdy), 128'd0);
      end
      rdy_in = 1'b1;
      @(negedge clk);
      chk("release_o_valid", CPC, 128'(o_vld), 128'd0);
      chk("release_o_ready", CPC, 128'(o_rdy), 128'd1);

      // Abort mid-block at column counter 2 (single BUSY cycle when all columns mix at once).
      send(V_IN, 1'b0, 1'b0, V_OUT, a0);
      repeat ((CPC == 1) ? 2 : ((CPC == 2) ? 1 : 0)) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_o_valid", CPC, 128'(o_vld), 128'd0);
      chk("abort_o_data",  CPC, dout, '0);
      chk("abort_o_ready", CPC, 128'(o_rdy), 128'd1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      send(V2_IN, 1'b0, 1'b0, V2_OUT, a0);

`ifdef MIX_COLUMNS_INV_EN
      send(V_OUT, 1'b0, 1'b1, V_IN, a0);
      send(V_OUT, 1'b1, 1'b1, V_OUT, a0);
      for (int i = 0; i < 1000; i++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        y = model_mix(x);
        send(x, 1'b0, 1'b0, y, a0);
        send(y, 1'b0, 1'b1, x, a0);
      end
`endif

      t = 0;
      while (q.size() != 0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("drain", CPC, 128'(q.size()), 128'd0);
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_dut[0].done && g_dut[1].done && g_dut[2].done);
      #500_000;
    join_any
    disable fork;
    if (!(g_dut[0].done && g_dut[1].done && g_dut[2].done)) begin
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: done=%b%b%b required 111",
               g_dut[2].done, g_dut[1].done, g_dut[0].done);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
